// File: rtl/cobs_frame_decoder_if.sv
// Byte-stream bus between the UART receive path and the COBS frame decoder,
// carrying the raw received bytes in and the decoded payload, status and counters out.
interface cobs_frame_decoder_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic [7:0]       in_byte;
    logic             in_error;
    logic             out_valid;
    logic [7:0]       out_byte;
    logic             out_last;
    logic             frame_err;
    logic [CNT_W-1:0] frame_count;
    logic [CNT_W-1:0] err_count;

    modport master (
        output in_valid, in_byte, in_error,
        input  out_valid, out_byte, out_last, frame_err, frame_count, err_count
    );

    modport slave (
        input  in_valid, in_byte, in_error,
        output out_valid, out_byte, out_last, frame_err, frame_count, err_count
    );
endinterface

// File: rtl/cobs_frame_decoder.sv
// COBS decoder for the host->probe command link: turns the 0x00-delimited byte stream
// into strobed payload bytes with a last-byte marker and per-frame error pulses.
module cobs_frame_decoder #(
    parameter int MAX_LEN = 1024,
    parameter int CNT_W   = 16
) (
    input logic                 clk,
    input logic                 rst,
    cobs_frame_decoder_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {SYNC, CODE, DATA} state_t;

    state_t           state_q, state_d;
    logic [7:0]       remain_q, remain_d;
    logic             blk255_q, blk255_d;
    logic             pend_q, pend_d;
    logic             hold_full_q, hold_full_d;
    logic [7:0]       hold_q, hold_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_byte_q, out_byte_d;
    logic             out_last_q, out_last_d;
    logic             frame_err_q, frame_err_d;
    logic [CNT_W-1:0] frame_count_q, frame_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             prod_en;
    logic [7:0]       prod_byte;
    logic             err;

    always_comb begin
        state_d       = state_q;
        remain_d      = remain_q;
        blk255_d      = blk255_q;
        pend_d        = pend_q;
        hold_full_d   = hold_full_q;
        hold_d        = hold_q;
        len_d         = len_q;
        out_valid_d   = 1'b0;
        out_byte_d    = out_byte_q;
        out_last_d    = 1'b0;
        frame_err_d   = 1'b0;
        frame_count_d = frame_count_q;
        err_count_d   = err_count_q;
        prod_en       = 1'b0;
        prod_byte     = 8'h00;
        err           = 1'b0;

        // A UART framing error wins over any byte strobed alongside it
        if (bus.in_error) begin
            if (state_q != SYNC) begin
                err     = 1'b1;
                state_d = SYNC;
            end
        end else if (bus.in_valid) begin
            case (state_q)
                SYNC: begin
                    if (bus.in_byte == 8'h00) state_d = CODE;
                end
                CODE: begin
                    if (bus.in_byte == 8'h00) begin
                        pend_d = 1'b0;
                        len_d  = '0;
                        if (hold_full_q) begin
                            out_valid_d   = 1'b1;
                            out_byte_d    = hold_q;
                            out_last_d    = 1'b1;
                            hold_full_d   = 1'b0;
                            frame_count_d = frame_count_q + CNT_W'(1);
                        end
                    end else begin
                        prod_en  = pend_q;
                        remain_d = bus.in_byte - 8'd1;
                        blk255_d = (bus.in_byte == 8'hFF);
                        if (bus.in_byte == 8'h01) begin
                            pend_d = 1'b1;
                        end else begin
                            pend_d  = 1'b0;
                            state_d = DATA;
                        end
                    end
                end
                DATA: begin
                    // A zero inside a block is also the next frame's delimiter
                    if (bus.in_byte == 8'h00) begin
                        err     = 1'b1;
                        state_d = CODE;
                    end else begin
                        prod_en   = 1'b1;
                        prod_byte = bus.in_byte;
                        remain_d  = remain_q - 8'd1;
                        if (remain_q == 8'd1) begin
                            state_d = CODE;
                            pend_d  = !blk255_q;
                        end
                    end
                end
                default: state_d = SYNC;
            endcase
        end

        // One-byte hold delays emission so the final byte can carry out_last
        if (prod_en) begin
            if (len_q == LEN_W'(MAX_LEN)) begin
                err     = 1'b1;
                state_d = SYNC;
            end else begin
                len_d       = len_q + LEN_W'(1);
                hold_d      = prod_byte;
                hold_full_d = 1'b1;
                if (hold_full_q) begin
                    out_valid_d = 1'b1;
                    out_byte_d  = hold_q;
                end
            end
        end

        if (err) begin
            frame_err_d = 1'b1;
            err_count_d = err_count_q + CNT_W'(1);
            hold_full_d = 1'b0;
            pend_d      = 1'b0;
            len_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= SYNC;
            pend_q        <= 1'b0;
            hold_full_q   <= 1'b0;
            len_q         <= '0;
            out_valid_q   <= 1'b0;
            out_byte_q    <= 8'h00;
            out_last_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_count_q <= '0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            hold_full_q   <= hold_full_d;
            len_q         <= len_d;
            out_valid_q   <= out_valid_d;
            out_byte_q    <= out_byte_d;
            out_last_q    <= out_last_d;
            frame_err_q   <= frame_err_d;
            frame_count_q <= frame_count_d;
            err_count_q   <= err_count_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_q   <= hold_d;
        remain_q <= remain_d;
        blk255_q <= blk255_d;
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_byte    = out_byte_q;
    assign bus.out_last    = out_last_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.frame_count = frame_count_q;
    assign bus.err_count   = err_count_q;
endmodule

// File: tb/tb_cobs_frame_decoder.sv
// Bench for cobs_frame_decoder: a table of per-cycle stimulus with expected outputs,
// replayed through a one-deep scoreboard; a second instance has MAX_LEN=4 for the length limit.
module tb_cobs_frame_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic       in_error = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cobs_frame_decoder_if #(.CNT_W(16)) if0 ();
    cobs_frame_decoder_if #(.CNT_W(16)) if1 ();

    assign if0.in_valid = in_valid;
    assign if0.in_byte  = in_byte;
    assign if0.in_error = in_error;
    assign if1.in_valid = in_valid;
    assign if1.in_byte  = in_byte;
    assign if1.in_error = in_error;

    cobs_frame_decoder #(.MAX_LEN(1024), .CNT_W(16)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    cobs_frame_decoder #(.MAX_LEN(4),    .CNT_W(16)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    typedef struct {
        logic        r;
        logic        v;
        logic [7:0]  b;
        logic        e;
        logic        sel;
        logic        ev;
        logic [7:0]  eb;
        logic        el;
        logic        ef;
        logic        cc;
        logic [15:0] fc;
        logic [15:0] ec;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    task automatic add(input logic r, input logic v, input logic [7:0] b, input logic e,
                       input logic s, input logic ev, input logic [7:0] eb,
                       input logic el, input logic ef);
        vec_t x;
        x.r = r; x.v = v; x.b = b; x.e = e; x.sel = s;
        x.ev = ev; x.eb = eb; x.el = el; x.ef = ef;
        x.cc = 1'b0; x.fc = '0; x.ec = '0;
        vecs.push_back(x);
    endtask

    task automatic nb(input logic [7:0] b, input logic s);
        add(1'b0, 1'b1, b, 1'b0, s, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic ob(input logic [7:0] b, input logic s, input logic [7:0] eb, input logic el);
        add(1'b0, 1'b1, b, 1'b0, s, 1'b1, eb, el, 1'b0);
    endtask

    task automatic fb(input logic [7:0] b, input logic s);
        add(1'b0, 1'b1, b, 1'b0, s, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic cnt(input logic [15:0] fc, input logic [15:0] ec);
        vec_t x;
        x = vecs.pop_back();
        x.cc = 1'b1; x.fc = fc; x.ec = ec;
        vecs.push_back(x);
    endtask

    task automatic cmp(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vector %0d): got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic check_out(input vec_t x, input int idx);
        logic        ov, ol, fe;
        logic [7:0]  obv;
        logic [15:0] fcv, ecv;
        if (x.sel) begin
            ov = if1.out_valid; ol = if1.out_last; fe = if1.frame_err; obv = if1.out_byte;
            fcv = if1.frame_count; ecv = if1.err_count;
        end else begin
            ov = if0.out_valid; ol = if0.out_last; fe = if0.frame_err; obv = if0.out_byte;
            fcv = if0.frame_count; ecv = if0.err_count;
        end
        cmp("out_valid", idx, 32'(ov), 32'(x.ev));
        cmp("frame_err", idx, 32'(fe), 32'(x.ef));
        if (x.ev) begin
            cmp("out_byte", idx, 32'(obv), 32'(x.eb));
            cmp("out_last", idx, 32'(ol), 32'(x.el));
        end
        if (x.r) begin
            cmp("reset_out_byte", idx, 32'(obv), 32'h0);
            cmp("reset_out_last", idx, 32'(ol), 32'h0);
            cmp("reset_frame_count", idx, 32'(fcv), 32'h0);
            cmp("reset_err_count", idx, 32'(ecv), 32'h0);
        end
        if (x.cc) begin
            cmp("frame_count", idx, 32'(fcv), 32'(x.fc));
            cmp("err_count", idx, 32'(ecv), 32'(x.ec));
        end
    endtask

    initial begin
        int idx_q[$];

        // Reset with no byte pending
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Two blocks with an implicit zero between them
        nb(8'h00, 0); nb(8'h03, 0); nb(8'h11, 0);
        ob(8'h22, 0, 8'h11, 0); ob(8'h02, 0, 8'h22, 0); ob(8'h33, 0, 8'h00, 0);
        ob(8'h00, 0, 8'h33, 1); cnt(16'd1, 16'd0);

        // Frame whose only payload is a single zero
        nb(8'h01, 0); nb(8'h01, 0); ob(8'h00, 0, 8'h00, 1); cnt(16'd2, 16'd0);

        // Full 0xFF block: 254 bytes, no implicit zero
        nb(8'h00, 0); nb(8'hFF, 0); nb(8'h01, 0);
        for (int i = 0; i < 253; i++) ob(8'h01, 0, 8'h01, 0);
        ob(8'h00, 0, 8'h01, 1); cnt(16'd3, 16'd0);

        // Premature delimiter inside a block
        nb(8'h00, 0); nb(8'h04, 0); nb(8'hAA, 0); fb(8'h00, 0); cnt(16'd3, 16'd1);
        nb(8'h02, 0); nb(8'hBB, 0); ob(8'h00, 0, 8'hBB, 1); cnt(16'd4, 16'd1);

        // UART error mid-frame, then resync
        nb(8'h00, 0); nb(8'h02, 0); nb(8'hCC, 0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1); cnt(16'd4, 16'd2);
        nb(8'h05, 0); nb(8'hDD, 0); nb(8'h00, 0);
        nb(8'h02, 0); nb(8'hEE, 0); ob(8'h00, 0, 8'hEE, 1); cnt(16'd5, 16'd2);

        // in_error together with a delimiter, then in_error while in SYNC
        nb(8'h02, 0); nb(8'h77, 0);
        add(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1); cnt(16'd5, 16'd3);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0); cnt(16'd5, 16'd3);
        nb(8'h00, 0); nb(8'h02, 0); nb(8'h88, 0); ob(8'h00, 0, 8'h88, 1); cnt(16'd6, 16'd3);

        // MAX_LEN=4 instance: overlong frame, recovery, exactly-full frame
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        nb(8'h00, 1); nb(8'h06, 1); nb(8'h01, 1);
        ob(8'h02, 1, 8'h01, 0); ob(8'h03, 1, 8'h02, 0); ob(8'h04, 1, 8'h03, 0);
        fb(8'h05, 1); cnt(16'd0, 16'd1);
        nb(8'h00, 1); nb(8'h02, 1); nb(8'h09, 1); ob(8'h00, 1, 8'h09, 1); cnt(16'd1, 16'd1);
        nb(8'h05, 1); nb(8'h01, 1);
        ob(8'h02, 1, 8'h01, 0); ob(8'h03, 1, 8'h02, 0); ob(8'h04, 1, 8'h03, 0);
        ob(8'h00, 1, 8'h04, 1); cnt(16'd2, 16'd1);

        // Reset mid-frame with a byte strobed in the same cycle
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        nb(8'h00, 0); nb(8'h03, 0); nb(8'h11, 0); ob(8'h22, 0, 8'h11, 0);
        add(1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        nb(8'h02, 0); nb(8'h44, 0); nb(8'h00, 0);
        nb(8'h02, 0); nb(8'h55, 0); ob(8'h00, 0, 8'h55, 1); cnt(16'd1, 16'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            if (sb.size() > 0) check_out(sb.pop_front(), idx_q.pop_front());
            rst      = vecs[i].r;
            in_valid = vecs[i].v;
            in_byte  = vecs[i].b;
            in_error = vecs[i].e;
            sb.push_back(vecs[i]);
            idx_q.push_back(i);
        end
        @(negedge clk);
        if (sb.size() > 0) check_out(sb.pop_front(), idx_q.pop_front());
        rst      = 1'b0;
        in_valid = 1'b0;
        in_error = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
